// File: rtl/ssd_hba_emu.sv
// SATA HBA user-interface emulator. It serves READ/WRITE sector commands from on-chip BRAM,
// so the SSD adapter can run without a PHY or drive.
`timescale 1ns/1ps
module ssd_hba_emu #(
    parameter int unsigned MEM_SECTORS_LOG2 = 6,
    parameter int unsigned RD_FIFO_DEPTH    = 512,
    parameter int unsigned WR_FIFO_DEPTH    = 512,
    parameter int unsigned CMD_LATENCY      = 4,
    parameter int unsigned LINK_INIT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  cmd,
    input  logic        cmd_en,
    input  logic [47:0] lba,
    input  logic [15:0] sectorcnt,
    output logic        cmd_success,
    output logic        cmd_failed,
    output logic        ncq_idle,
    output logic        link_initialized,
    output logic [31:0] rdata,
    output logic        rdata_empty,
    input  logic        rdata_next,
    input  logic [31:0] wdata,
    input  logic        wdata_en,
    output logic        wdata_full,
    output logic [15:0] wr_drop_cnt,
    output logic [15:0] cmd_ignored_cnt
);
    localparam int unsigned MemAw      = MEM_SECTORS_LOG2 + 7;
    localparam int unsigned MemWords   = 1 << MemAw;
    localparam int unsigned MemSectors = 1 << MEM_SECTORS_LOG2;
    localparam int unsigned RdAw       = $clog2(RD_FIFO_DEPTH);
    localparam int unsigned WrAw       = $clog2(WR_FIFO_DEPTH);
    localparam logic [2:0]  CmdRead    = 3'd1;
    localparam logic [2:0]  CmdWrite   = 3'd2;
    // One word may still be in flight from BRAM, so stop issuing two short of full.
    localparam logic [RdAw:0] RdHiWater = (RdAw + 1)'(RD_FIFO_DEPTH - 2);
    localparam logic [WrAw:0] WrFull    = (WrAw + 1)'(WR_FIFO_DEPTH);

    typedef enum logic [2:0] {
        StLinkDown,
        StIdle,
        StWait,
        StRdXfer,
        StWrXfer,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      tmr_q, tmr_d;
    logic [22:0]      rem_q, rem_d;
    logic [MemAw-1:0] addr_q, addr_d;
    logic             is_rd_q, is_rd_d;
    logic             cmd_failed_q, cmd_failed_d;
    logic [15:0]      ign_cnt_q, drop_cnt_q;

    logic [31:0]      bram [MemWords];
    logic [31:0]      bram_rdata_q;
    logic             rd_vld_q, rd_last_q;
    logic             rd_issue;

    logic [31:0]      rf_mem [RD_FIFO_DEPTH];
    logic [RdAw-1:0]  rf_wptr_q, rf_rptr_q;
    logic [RdAw:0]    rf_cnt_q;
    logic             rf_push, rf_pop;

    logic [31:0]      wf_mem [WR_FIFO_DEPTH];
    logic [WrAw-1:0]  wf_wptr_q, wf_rptr_q;
    logic [WrAw:0]    wf_cnt_q;
    logic             wf_push, wf_pop;

    logic [48:0]      cmd_end;
    logic             cmd_bad;

    assign cmd_end = {1'b0, lba} + 49'(sectorcnt);

    always_comb begin
        cmd_bad = 1'b0;
        if (cmd != CmdRead && cmd != CmdWrite) begin
            cmd_bad = 1'b1;
        end else if (sectorcnt == 16'd0) begin
            cmd_bad = 1'b1;
        end else if (lba[47:MEM_SECTORS_LOG2] != '0) begin
            cmd_bad = 1'b1;
        end else if (cmd_end > 49'(MemSectors)) begin
            cmd_bad = 1'b1;
        end
    end

    assign rdata_empty      = (rf_cnt_q == '0);
    assign wdata_full       = (wf_cnt_q == WrFull);
    assign rdata            = rf_mem[rf_rptr_q];
    assign rf_push          = rd_vld_q;
    assign rf_pop           = rdata_next & ~rdata_empty;
    assign wf_push          = wdata_en & ~wdata_full & (state_q != StLinkDown);
    assign wf_pop           = (state_q == StWrXfer) & (wf_cnt_q != '0);
    assign rd_issue         = (state_q == StRdXfer) & (rem_q != '0) & (rf_cnt_q <= RdHiWater);

    assign cmd_success      = (state_q == StDone);
    assign cmd_failed       = cmd_failed_q;
    assign ncq_idle         = (state_q == StIdle);
    assign link_initialized = (state_q != StLinkDown);
    assign wr_drop_cnt      = drop_cnt_q;
    assign cmd_ignored_cnt  = ign_cnt_q;

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        rem_d        = rem_q;
        addr_d       = addr_q;
        is_rd_d      = is_rd_q;
        cmd_failed_d = 1'b0;
        unique case (state_q)
            StLinkDown: begin
                if (tmr_q == 16'(LINK_INIT_CYCLES - 1)) begin
                    state_d = StIdle;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            StIdle: begin
                if (cmd_en) begin
                    if (cmd_bad) begin
                        cmd_failed_d = 1'b1;
                    end else begin
                        state_d = StWait;
                        tmr_d   = '0;
                        rem_d   = {sectorcnt, 7'd0};
                        addr_d  = {lba[MEM_SECTORS_LOG2-1:0], 7'd0};
                        is_rd_d = (cmd == CmdRead);
                    end
                end
            end
            StWait: begin
                // Accept cycle plus the wait cycles add up to CMD_LATENCY.
                if (32'(tmr_q) + 32'd2 >= 32'(CMD_LATENCY)) begin
                    state_d = is_rd_q ? StRdXfer : StWrXfer;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            StRdXfer: begin
                if (rd_issue) begin
                    rem_d  = rem_q - 23'd1;
                    addr_d = addr_q + MemAw'(1);
                end
                if (rd_vld_q && rd_last_q) begin
                    state_d = StDone;
                end
            end
            StWrXfer: begin
                if (wf_pop) begin
                    rem_d  = rem_q - 23'd1;
                    addr_d = addr_q + MemAw'(1);
                    if (rem_q == 23'd1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StLinkDown;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StLinkDown;
            tmr_q        <= '0;
            rem_q        <= '0;
            addr_q       <= '0;
            is_rd_q      <= 1'b0;
            cmd_failed_q <= 1'b0;
            ign_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            rf_wptr_q    <= '0;
            rf_rptr_q    <= '0;
            rf_cnt_q     <= '0;
            wf_wptr_q    <= '0;
            wf_rptr_q    <= '0;
            wf_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            rem_q        <= rem_d;
            addr_q       <= addr_d;
            is_rd_q      <= is_rd_d;
            cmd_failed_q <= cmd_failed_d;
            rd_vld_q     <= rd_issue;
            rd_last_q    <= rd_issue & (rem_q == 23'd1);
            if (cmd_en && state_q != StIdle && ign_cnt_q != 16'hffff) begin
                ign_cnt_q <= ign_cnt_q + 16'd1;
            end
            if (wdata_en && wdata_full && drop_cnt_q != 16'hffff) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (rf_push) rf_wptr_q <= rf_wptr_q + RdAw'(1);
            if (rf_pop)  rf_rptr_q <= rf_rptr_q + RdAw'(1);
            if (rf_push && !rf_pop) begin
                rf_cnt_q <= rf_cnt_q + (RdAw + 1)'(1);
            end else if (!rf_push && rf_pop) begin
                rf_cnt_q <= rf_cnt_q - (RdAw + 1)'(1);
            end
            if (wf_push) wf_wptr_q <= wf_wptr_q + WrAw'(1);
            if (wf_pop)  wf_rptr_q <= wf_rptr_q + WrAw'(1);
            if (wf_push && !wf_pop) begin
                wf_cnt_q <= wf_cnt_q + (WrAw + 1)'(1);
            end else if (!wf_push && wf_pop) begin
                wf_cnt_q <= wf_cnt_q - (WrAw + 1)'(1);
            end
        end
    end

    // Storage arrays carry no reset; BRAM contents survive a reset.
    always_ff @(posedge clk) begin
        if (wf_pop)   bram[addr_q] <= wf_mem[wf_rptr_q];
        if (rd_issue) bram_rdata_q <= bram[addr_q];
        if (rf_push)  rf_mem[rf_wptr_q] <= bram_rdata_q;
        if (wf_push)  wf_mem[wf_wptr_q] <= wdata;
    end

endmodule

// File: tb/tb_ssd_hba_emu.sv
// Scoreboard bench for ssd_hba_emu. A shadow sector model supplies the expected read data,
// and command outcomes are checked pulse by pulse.
`timescale 1ns/1ps
module tb_ssd_hba_emu;
    localparam logic [2:0] CmdRd = 3'd1;
    localparam logic [2:0] CmdWr = 3'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  cmd = '0;
    logic        cmd_en = 1'b0;
    logic [47:0] lba = '0;
    logic [15:0] sectorcnt = '0;
    logic        cmd_success, cmd_failed, ncq_idle, link_initialized;
    logic [31:0] rdata;
    logic        rdata_empty;
    logic        rdata_next = 1'b0;
    logic [31:0] wdata = '0;
    logic        wdata_en = 1'b0;
    logic        wdata_full;
    logic [15:0] wr_drop_cnt, cmd_ignored_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          succ_seen = 0;
    int          fail_seen = 0;
    int          exp_ign = 0;
    logic [31:0] model [8192];
    logic [31:0] exp_q [$];
    logic [31:0] wr_q [$];

    ssd_hba_emu dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_en(cmd_en), .lba(lba),
        .sectorcnt(sectorcnt), .cmd_success(cmd_success), .cmd_failed(cmd_failed),
        .ncq_idle(ncq_idle), .link_initialized(link_initialized), .rdata(rdata),
        .rdata_empty(rdata_empty), .rdata_next(rdata_next), .wdata(wdata),
        .wdata_en(wdata_en), .wdata_full(wdata_full), .wr_drop_cnt(wr_drop_cnt),
        .cmd_ignored_cnt(cmd_ignored_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmd_success) succ_seen++;
        if (cmd_failed) fail_seen++;
        if (!reset) check_eq("excl", 64'(cmd_success & cmd_failed), 64'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input int l, input int n);
        cmd = c;
        lba = 48'(l);
        sectorcnt = 16'(n);
        cmd_en = 1'b1;
        tick();
        cmd_en = 1'b0;
    endtask

    task automatic issue_wide(input logic [2:0] c, input logic [47:0] l, input int n);
        cmd = c;
        lba = l;
        sectorcnt = 16'(n);
        cmd_en = 1'b1;
        tick();
        cmd_en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic exp_ok);
        for (int i = 0; i < 20000; i++) begin
            if (cmd_success || cmd_failed) break;
            tick();
        end
        check_eq({tag, "_success"}, 64'(cmd_success), 64'(exp_ok));
        check_eq({tag, "_failed"}, 64'(cmd_failed), 64'(!exp_ok));
        tick();
        check_eq({tag, "_pulse1"}, 64'(cmd_success | cmd_failed), 64'd0);
    endtask

    task automatic drain(input int n, input int period);
        int got;
        logic [31:0] e;
        got = 0;
        for (int c = 0; c < 40000 && got < n; c++) begin
            if (!rdata_empty && (c % period == 0)) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                check_eq("rdata", 64'(rdata), 64'(e));
                rdata_next = 1'b1;
                got++;
            end else begin
                rdata_next = 1'b0;
            end
            tick();
        end
        rdata_next = 1'b0;
        check_eq("rd_count", 64'(got), 64'(n));
    endtask

    task automatic push_words();
        for (int c = 0; c < 20000 && wr_q.size() != 0; c++) begin
            if (!wdata_full) begin
                wdata = wr_q.pop_front();
                wdata_en = 1'b1;
            end else begin
                wdata_en = 1'b0;
            end
            tick();
        end
        wdata_en = 1'b0;
        check_eq("wr_left", 64'(wr_q.size()), 64'd0);
    endtask

    task automatic write_cmd(input string tag, input int l, input int n);
        logic [31:0] w;
        for (int i = 0; i < n * 128; i++) begin
            w = $urandom;
            model[l * 128 + i] = w;
            wr_q.push_back(w);
        end
        issue(CmdWr, l, n);
        fork
            push_words();
            wait_done(tag, 1'b1);
        join
    endtask

    task automatic read_cmd(input string tag, input int l, input int n, input int period);
        for (int i = 0; i < n * 128; i++) exp_q.push_back(model[l * 128 + i]);
        issue(CmdRd, l, n);
        fork
            drain(n * 128, period);
            wait_done(tag, 1'b1);
        join
        check_eq({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic link_up(input logic probe_cmd);
        for (int k = 1; k <= 16; k++) begin
            cmd = CmdRd;
            cmd_en = probe_cmd && (k == 3);
            tick();
            if (k == 15) check_eq("link_early", 64'(link_initialized), 64'd0);
            if (k == 16) begin
                check_eq("link_up", 64'(link_initialized), 64'd1);
                check_eq("idle_up", 64'(ncq_idle), 64'd1);
            end
        end
        cmd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, f0;
        repeat (3) tick();
        check_eq("rst_success", 64'(cmd_success), 64'd0);
        check_eq("rst_failed", 64'(cmd_failed), 64'd0);
        check_eq("rst_idle", 64'(ncq_idle), 64'd0);
        check_eq("rst_link", 64'(link_initialized), 64'd0);
        check_eq("rst_rempty", 64'(rdata_empty), 64'd1);
        check_eq("rst_wfull", 64'(wdata_full), 64'd0);
        check_eq("rst_drop", 64'(wr_drop_cnt), 64'd0);
        check_eq("rst_ign", 64'(cmd_ignored_cnt), 64'd0);

        reset = 1'b0;
        link_up(1'b1);
        exp_ign = 1;
        check_eq("ign_prelink", 64'(cmd_ignored_cnt), 64'(exp_ign));

        // Data precedes its command.
        for (int i = 0; i < 128; i++) begin
            model[3 * 128 + i] = 32'(i);
            wr_q.push_back(32'(i));
        end
        push_words();
        issue(CmdWr, 3, 1);
        wait_done("wr3", 1'b1);
        read_cmd("rd3", 3, 1, 1);

        write_cmd("wr0_8", 0, 8);
        for (int i = 0; i < 1024; i++) exp_q.push_back(model[i]);
        issue(CmdRd, 0, 8);
        fork
            drain(1024, 4);
            wait_done("rd0_8", 1'b1);
            begin
                repeat (40) tick();
                issue(CmdWr, 0, 1);
                exp_ign++;
            end
        join
        check_eq("rd0_8_left", 64'(exp_q.size()), 64'd0);
        check_eq("ign_midread", 64'(cmd_ignored_cnt), 64'(exp_ign));

        write_cmd("wr60_4", 60, 4);
        read_cmd("rd60_4", 60, 4, 1);

        issue(CmdRd, 60, 5);
        wait_done("rej_range", 1'b0);
        issue(3'd5, 0, 1);
        wait_done("rej_cmd", 1'b0);
        issue(CmdRd, 0, 0);
        wait_done("rej_zero", 1'b0);
        issue_wide(CmdRd, 48'h0100_0000_0000, 1);
        wait_done("rej_lba", 1'b0);
        repeat (8) tick();
        check_eq("rej_nodata", 64'(rdata_empty), 64'd1);

        for (int i = 0; i < 513; i++) begin
            wdata = 32'(i);
            wdata_en = 1'b1;
            tick();
        end
        wdata_en = 1'b0;
        check_eq("ovf_drop", 64'(wr_drop_cnt), 64'd1);
        check_eq("ovf_full", 64'(wdata_full), 64'd1);

        s0 = succ_seen;
        f0 = fail_seen;
        issue(CmdWr, 10, 4);
        repeat (20) tick();
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst2_rempty", 64'(rdata_empty), 64'd1);
        check_eq("rst2_wfull", 64'(wdata_full), 64'd0);
        check_eq("rst2_drop", 64'(wr_drop_cnt), 64'd0);
        check_eq("rst2_link", 64'(link_initialized), 64'd0);
        reset = 1'b0;
        exp_ign = 0;
        link_up(1'b0);
        check_eq("rst2_nosucc", 64'(succ_seen), 64'(s0));
        check_eq("rst2_nofail", 64'(fail_seen), 64'(f0));
        check_eq("rst2_ign", 64'(cmd_ignored_cnt), 64'(exp_ign));

        read_cmd("rd3_retained", 3, 1, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
